otter_cu_fsm: RTL and testbench

- Multicycle control FSM for the Otter RV32I core; sequences every instruction through fetch, execute and optional writeback, and enters interrupts.
- Sits beside the combinational control decoder. It reads the same ir[6:0] and ir[14:12] fields and drives `int_taken` into that decoder, which then selects the mtvec PC source.
- Produces all write and read enables for the PC, register file, memory and CSR file.

---
 rtl/otter_cu_fsm.sv | 198 +++++++++++++++++++
 tb/tb_otter_cu_fsm.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/otter_cu_fsm.sv
// -----------------------------------------------------------------------------
// otter_cu_fsm
//
// Multicycle control FSM for the Otter RV32I core. It steps every instruction
// through FETCH, EXEC and, for loads only, WB. Between instructions it can
// divert through INTR to enter an interrupt handler. It runs beside the
// combinational control decoder. Both blocks decode the same ir fields.
// int_taken tells the decoder to select mtvec as the next PC.
//
// Ports:
//   CLK        system clock, rising edge active
//   RST        asynchronous active-high reset
//   intr       interrupt request (level, already gated by mie)
//   opcode     ir[6:0]
//   func3      ir[14:12]
//   pcWrite    PC register load enable
//   regWrite   register file write enable
//   memWE2     data-port write enable
//   memRDEN1   instruction-port read enable
//   memRDEN2   data-port read enable
//   reset      synchronous clear to the PC and datapath
//   csr_WE     CSR file write enable
//   int_taken  interrupt entry (decoder selects mtvec; CSR saves mepc)
//   mret_exec  MRET executing (CSR file restores mie)
//
// Build option:
//   OTTER_CU_INTR_SYNC_EN - when defined, intr passes through a 2-flop
//   synchronizer before the FSM samples it. This adds 2 cycles of latency.
//   When undefined, intr is assumed to be synchronous to CLK.
//
// Only the state register (and the optional synchronizer) is sequential.
// The outputs are decoded from state, so the asynchronous reset reaches the
// outputs in the same cycle that RST is asserted.
// -----------------------------------------------------------------------------
module otter_cu_fsm (
  input  logic       CLK,
  input  logic       RST,
  input  logic       intr,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  output logic       pcWrite,
  output logic       regWrite,
  output logic       memWE2,
  output logic       memRDEN1,
  output logic       memRDEN2,
  output logic       reset,
  output logic       csr_WE,
  output logic       int_taken,
  output logic       mret_exec
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_RG3    = 7'b0110011;
  localparam logic [6:0] OP_SYS    = 7'b1110011;

  localparam logic [2:0] F3_MRET   = 3'b000;
  localparam logic [2:0] F3_CSRRW  = 3'b001;

  state_t state;
  state_t next_state;
  logic   intr_s;

`ifdef OTTER_CU_INTR_SYNC_EN
  logic [1:0] intr_sync;

  // Two-flop synchronizer for an intr source that is not synchronous to CLK.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      intr_sync <= 2'b00;
    end else begin
      intr_sync <= {intr_sync[0], intr};
    end
  end

  assign intr_s = intr_sync[1];
`else
  assign intr_s = intr;
`endif

  // State register. An asynchronous reset aborts any instruction in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_INIT;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and output decode.
  // intr is sampled only on the last cycle of an instruction.
  always_comb begin
    next_state = ST_INIT;
    pcWrite    = 1'b0;
    regWrite   = 1'b0;
    memWE2     = 1'b0;
    memRDEN1   = 1'b0;
    memRDEN2   = 1'b0;
    reset      = 1'b0;
    csr_WE     = 1'b0;
    int_taken  = 1'b0;
    mret_exec  = 1'b0;

    case (state)
      ST_INIT: begin
        reset      = 1'b1;
        next_state = ST_FETCH;
      end

      ST_FETCH: begin
        memRDEN1   = 1'b1;
        next_state = ST_EXEC;
      end

      ST_EXEC: begin
        // Every non-load opcode finishes here, so intr is sampled here.
        // A load defers both its PC update and the intr sample to WB.
        if (intr_s) begin
          next_state = ST_INTR;
        end else begin
          next_state = ST_FETCH;
        end

        case (opcode)
          OP_LOAD: begin
            memRDEN2   = 1'b1;
            next_state = ST_WB;
          end
          OP_STORE: begin
            memWE2  = 1'b1;
            pcWrite = 1'b1;
          end
          OP_BRANCH: begin
            pcWrite = 1'b1;
          end
          OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_RG3: begin
            pcWrite  = 1'b1;
            regWrite = 1'b1;
          end
          OP_SYS: begin
            pcWrite = 1'b1;
            if (func3 == F3_CSRRW) begin
              regWrite = 1'b1;
              csr_WE   = 1'b1;
            end else if (func3 == F3_MRET) begin
              mret_exec = 1'b1;
            end else begin
              mret_exec = 1'b0;
            end
          end
          default: begin
            // An unknown opcode is executed as a NOP; it does not trap.
            pcWrite = 1'b1;
          end
        endcase
      end

      ST_WB: begin
        regWrite = 1'b1;
        pcWrite  = 1'b1;
        if (intr_s) begin
          next_state = ST_INTR;
        end else begin
          next_state = ST_FETCH;
        end
      end

      ST_INTR: begin
        // intr is still high here until the handler clears it.
        // Ignoring intr in this state prevents a second interrupt entry.
        int_taken  = 1'b1;
        pcWrite    = 1'b1;
        next_state = ST_FETCH;
      end

      default: begin
        // An illegal encoding behaves like INIT and recovers through it.
        reset      = 1'b1;
        next_state = ST_INIT;
      end
    endcase
  end

endmodule

// File: tb/tb_otter_cu_fsm.sv
// -----------------------------------------------------------------------------
// tb_otter_cu_fsm - directed, self-checking bench for otter_cu_fsm.
// When the bench drives stimulus, it pushes the expected output vector onto
// a queue. When it samples the DUT outputs, it pops that vector and compares.
// Vector order: {pcWrite, regWrite, memWE2, memRDEN1, memRDEN2, reset,
//                csr_WE, int_taken, mret_exec}
// -----------------------------------------------------------------------------
module tb_otter_cu_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       intr = 1'b0;
  logic [6:0] opcode = 7'b0110011;
  logic [2:0] func3 = 3'b000;
  logic       pcWrite, regWrite, memWE2, memRDEN1, memRDEN2;
  logic       reset, csr_WE, int_taken, mret_exec;

  otter_cu_fsm dut (
    .CLK       (CLK),
    .RST       (RST),
    .intr      (intr),
    .opcode    (opcode),
    .func3     (func3),
    .pcWrite   (pcWrite),
    .regWrite  (regWrite),
    .memWE2    (memWE2),
    .memRDEN1  (memRDEN1),
    .memRDEN2  (memRDEN2),
    .reset     (reset),
    .csr_WE    (csr_WE),
    .int_taken (int_taken),
    .mret_exec (mret_exec)
  );

  always #5 CLK = ~CLK;

  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] RG3    = 7'b0110011;
  localparam logic [6:0] SYS    = 7'b1110011;
  localparam logic [6:0] BOGUS  = 7'b1111111;

  localparam logic [8:0] V_RST   = 9'b000001000;
  localparam logic [8:0] V_FETCH = 9'b000100000;
  localparam logic [8:0] V_ALU   = 9'b110000000;
  localparam logic [8:0] V_LD    = 9'b000010000;
  localparam logic [8:0] V_WB    = 9'b110000000;
  localparam logic [8:0] V_ST    = 9'b101000000;
  localparam logic [8:0] V_PC    = 9'b100000000;
  localparam logic [8:0] V_CSR   = 9'b110000100;
  localparam logic [8:0] V_MRET  = 9'b100000001;
  localparam logic [8:0] V_INT   = 9'b100000010;

  logic [8:0] exp_q[$];
  string      tag_q[$];
  int         checks = 0;
  int         failures = 0;

  function automatic logic [8:0] outs();
    return {pcWrite, regWrite, memWE2, memRDEN1, memRDEN2,
            reset, csr_WE, int_taken, mret_exec};
  endfunction

  task automatic expect_vec(input logic [8:0] v, input string tag);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic chk();
    logic [8:0] e;
    string      t;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%b expected=<entry>", outs());
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (outs() === e) else begin
        failures++;
        $error("FAIL %s observed=%b expected=%b", t, outs(), e);
      end
    end
  endtask

  // Run one clock cycle: drive the inputs just after the rising edge,
  // then check the outputs at the falling edge.
  task automatic cyc(input logic [6:0] op, input logic [2:0] f3,
                     input logic irq, input logic [8:0] v, input string tag);
    @(posedge CLK);
    #1;
    opcode = op;
    func3  = f3;
    intr   = irq;
    expect_vec(v, tag);
    @(negedge CLK);
    chk();
  endtask

  initial begin : stim
    logic [6:0] alu_ops [5];
    alu_ops = '{LUI, AUIPC, JAL, JALR, OPIMM};

    // Reset held: INIT outputs.
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    expect_vec(V_RST, "rst_held");
    chk();

    // Release: the first cycle after deassertion is still INIT.
    @(posedge CLK);
    #1;
    RST = 1'b0;
    expect_vec(V_RST, "init_after_release");
    @(negedge CLK);
    chk();

    // Three R-type instructions back to back.
    for (int i = 0; i < 3; i++) begin
      cyc(RG3, 3'b000, 1'b0, V_FETCH, "rg3_fetch");
      cyc(RG3, 3'b000, 1'b0, V_ALU,   "rg3_exec");
    end

    // Load: FETCH, EXEC, WB.
    cyc(LOAD, 3'b010, 1'b0, V_FETCH, "ld_fetch");
    cyc(LOAD, 3'b010, 1'b0, V_LD,    "ld_exec");
    cyc(LOAD, 3'b010, 1'b0, V_WB,    "ld_wb");

    // Store with intr held high: interrupt entry, then no second entry.
    cyc(STORE, 3'b010, 1'b1, V_FETCH, "st_fetch");
    cyc(STORE, 3'b010, 1'b1, V_ST,    "st_exec");
    cyc(STORE, 3'b010, 1'b1, V_INT,   "st_intr");
    cyc(BRANCH, 3'b000, 1'b1, V_FETCH, "post_intr_fetch");
    cyc(BRANCH, 3'b000, 1'b0, V_PC,    "branch_exec");

    // An intr pulse that occurs only during a load's EXEC is lost.
    cyc(LOAD, 3'b000, 1'b0, V_FETCH, "ld2_fetch");
    cyc(LOAD, 3'b000, 1'b1, V_LD,    "ld2_exec_intr");
    cyc(LOAD, 3'b000, 1'b0, V_WB,    "ld2_wb");
    cyc(RG3,  3'b000, 1'b0, V_FETCH, "ld2_no_intr");
    cyc(RG3,  3'b000, 1'b0, V_ALU,   "rg3_after_ld2");

    // An intr sampled in WB enters the interrupt after the load completes.
    cyc(LOAD, 3'b000, 1'b0, V_FETCH, "ld3_fetch");
    cyc(LOAD, 3'b000, 1'b0, V_LD,    "ld3_exec");
    cyc(LOAD, 3'b000, 1'b1, V_WB,    "ld3_wb_intr");
    cyc(LOAD, 3'b000, 1'b0, V_INT,   "ld3_intr");
    cyc(SYS,  3'b001, 1'b0, V_FETCH, "csr_fetch");

    // System instructions.
    cyc(SYS, 3'b001, 1'b0, V_CSR,   "csrrw_exec");
    cyc(SYS, 3'b000, 1'b0, V_FETCH, "mret_fetch");
    cyc(SYS, 3'b000, 1'b0, V_MRET,  "mret_exec");
    cyc(SYS, 3'b010, 1'b0, V_FETCH, "csrrs_fetch");
    cyc(SYS, 3'b010, 1'b0, V_PC,    "csrrs_exec");

    // Other register-writing opcodes, and an unknown opcode.
    for (int i = 0; i < 5; i++) begin
      cyc(alu_ops[i], 3'b000, 1'b0, V_FETCH, "alu_fetch");
      cyc(alu_ops[i], 3'b000, 1'b0, V_ALU,   "alu_exec");
    end
    cyc(BOGUS, 3'b000, 1'b0, V_FETCH, "bogus_fetch");
    cyc(BOGUS, 3'b000, 1'b0, V_PC,    "bogus_exec");

    // Asynchronous reset asserted in the middle of a load's WB cycle.
    cyc(LOAD, 3'b000, 1'b0, V_FETCH, "ld4_fetch");
    cyc(LOAD, 3'b000, 1'b0, V_LD,    "ld4_exec");
    @(posedge CLK);
    #1;
    expect_vec(V_WB, "ld4_wb_before_rst");
    #1;
    chk();
    RST = 1'b1;
    #1;
    expect_vec(V_RST, "rst_mid_wb");
    chk();
    @(negedge CLK);
    expect_vec(V_RST, "rst_mid_wb_held");
    chk();
    @(posedge CLK);
    #1;
    RST = 1'b0;
    expect_vec(V_RST, "init_after_rst2");
    @(negedge CLK);
    chk();
    cyc(RG3, 3'b000, 1'b0, V_FETCH, "restart_fetch");
    cyc(RG3, 3'b000, 1'b0, V_ALU,   "restart_exec");

    // Every expected vector must have been consumed.
    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
